// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: quotient goes to LO, remainder to HI.
// One quotient bit per cycle via trial subtraction; sign fix-up runs in a final cycle.
module iter_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic             sgn_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             dbz_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] div_r;
  logic [CW-1:0]    cnt_r;

  logic             accept;
  logic             divisor_zero;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] quo_fixed;
  logic [WIDTH-1:0] rem_fixed;

  // Next-state decode; a zero divisor skips the iteration phase entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = divisor_zero ? FIX : CALC;
        end
      end
      CALC: begin
        if (cnt_r == LAST_CNT) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand conditioning at capture: magnitudes for DIV, raw bits for DIVU.
  always_comb begin
    accept       = (state == IDLE) && start;
    divisor_zero = (divisor == '0);
    dividend_mag = (is_signed && dividend[MSB]) ? WIDTH'(0 - dividend) : dividend;
    divisor_mag  = (is_signed && divisor[MSB])  ? WIDTH'(0 - divisor)  : divisor;
  end

  // One restoring step: the borrow out of the trial subtract is the less-than decision.
  always_comb begin
    shifted = {rem_r, quo_r[MSB]};
    trial   = shifted - {1'b0, div_r};
    borrow  = trial[WIDTH];
  end

  // Sign fix-up: quotient negative when operand signs differ, remainder follows the dividend.
  always_comb begin
    quo_fixed = (sgn_r && neg_q_r) ? WIDTH'(0 - quo_r) : quo_r;
    rem_fixed = (sgn_r && neg_r_r) ? WIDTH'(0 - rem_r) : rem_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_r       <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      dbz_r       <= 1'b0;
      quo_r       <= '0;
      rem_r       <= '0;
      div_r       <= '0;
      cnt_r       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == FIX);

      case (state)
        IDLE: begin
          if (accept) begin
            sgn_r   <= is_signed;
            neg_q_r <= dividend[MSB] ^ divisor[MSB];
            neg_r_r <= dividend[MSB];
            dbz_r   <= divisor_zero;
            // Divide-by-zero hands back the untouched dividend as the remainder.
            quo_r   <= divisor_zero ? dividend : dividend_mag;
            div_r   <= divisor_mag;
            rem_r   <= '0;
            cnt_r   <= '0;
          end
        end
        CALC: begin
          if (!borrow) begin
            rem_r <= trial[WIDTH-1:0];
          end else begin
            rem_r <= shifted[WIDTH-1:0];
          end
          quo_r <= {quo_r[MSB-1:0], ~borrow};
          cnt_r <= cnt_r + CW'(1);
        end
        FIX: begin
          div_by_zero <= dbz_r;
          if (dbz_r) begin
            quotient  <= '1;
            remainder <= quo_r;
          end else begin
            quotient  <= quo_fixed;
            remainder <= rem_fixed;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: stimulus pushes expected results, a negedge monitor
// pops and checks value, latency, busy length and done pulse width on every done.
module tb_iter_divider;

  localparam int unsigned W = 32;

  typedef struct {
    string      name;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic       dbz;
    int         done_cyc;
    int         busy_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  iter_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: compares every done against the oldest outstanding expectation.
  int   busy_cnt = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (done) begin
      chk("done_one_cycle", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 want no done (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_q"}, quotient, e.q);
        chk({e.name, "_r"}, remainder, e.r);
        chk({e.name, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.done_cyc));
        chk({e.name, "_busy_len"}, 32'(busy_cnt), 32'(e.busy_cyc));
      end
      busy_cnt = 0;
    end else if (!busy) begin
      busy_cnt = 0;
    end
    prev_done = done;
  end

  // Called at a negedge; start is sampled by the next posedge (E0) and dropped after it.
  task automatic issue(input string nm, input logic sg, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] q,
                       input logic [W-1:0] r, input logic z);
    exp_t e;
    e.name     = nm;
    e.q        = q;
    e.r        = r;
    e.dbz      = z;
    e.done_cyc = cyc + (z ? 2 : int'(W) + 2);
    e.busy_cyc = z ? 1 : int'(W) + 1;
    sb.push_back(e);
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 100; i++) begin
      if (done) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL %s_timeout: got no done want done within 100 cycles", nm);
    sb.delete();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_q", quotient, 32'h0);
    chk("rst_r", remainder, 32'h0);
    chk("rst_dbz", 32'(div_by_zero), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);

    issue("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    wait_done("divu_100_7");
    issue("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    wait_done("div_m7_2");
    issue("div_7_m2", 1'b1, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1, 1'b0);
    wait_done("div_7_m2");
    issue("divu_ffff_2", 1'b0, 32'hFFFFFFFF, 32'h2, 32'h7FFFFFFF, 32'h1, 1'b0);
    wait_done("divu_ffff_2");
    issue("div_m1_2", 1'b1, 32'hFFFFFFFF, 32'h2, 32'h0, 32'hFFFFFFFF, 1'b0);
    wait_done("div_m1_2");
    issue("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0);
    wait_done("div_ovf");
    issue("divu_8000_ffff", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    wait_done("divu_8000_ffff");
    issue("div_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    wait_done("div_m100_7");
    issue("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
    wait_done("divu_5_0");
    issue("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    wait_done("divu_9_3");
    issue("div_m100_0", 1'b1, 32'hFFFFFF9C, 32'd0, 32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1);
    wait_done("div_m100_0");

    // Start while busy must be ignored; outputs hold the previous result during CALC.
    issue("ignore_start", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (9) @(negedge clk);
    chk("hold_q", quotient, 32'hFFFFFFFF);
    chk("hold_r", remainder, 32'hFFFFFF9C);
    chk("hold_dbz", 32'(div_by_zero), 32'h1);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start");

    // Start in the done cycle is accepted.
    issue("b2b_first", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    wait_done("b2b_first");
    issue("b2b_second", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    wait_done("b2b_second");

    // Reset mid-operation aborts with no done pulse.
    issue("abort", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_q", quotient, 32'h0);
    chk("abort_r", remainder, 32'h0);
    chk("abort_dbz", 32'(div_by_zero), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    repeat (45) @(negedge clk);

    issue("post_rst_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    wait_done("post_rst_9_3");
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle restoring divider for MIPS DIV/DIVU. Produces a quotient for LO and a remainder for HI.
- Sits in the ALU next to the signed/unsigned less-than comparators. It is the sequential consumer of compare-and-subtract: each iteration trial-subtracts the divisor and uses the borrow as the "less-than" decision.
- The control unit starts an operation and stalls on busy until done.

Parameters:
- WIDTH, 32, operand/result width in bits. The iteration counter is $clog2(WIDTH) bits wide.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; captured with start
- dividend  input  WIDTH  numerator; captured with start
- divisor  input  WIDTH  denominator; captured with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  WIDTH  LO result
- remainder  output  WIDTH  HI result
- div_by_zero  output  1  set with done when captured divisor==0

Behaviour:
- Interface decision: one clock (clk); rst is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; all internal registers cleared.
  - rst mid-operation aborts the operation at that edge. No done pulse follows.
  - rst has priority over start.
- States:
  - IDLE -> CALC on start when divisor!=0.
  - IDLE -> FIX on start when divisor==0.
  - CALC -> FIX after the iteration with count==WIDTH-1.
  - FIX -> IDLE unconditionally.
- Capture at the start edge (E0):
  - Register is_signed.
  - neg_q = is_signed & (dividend[MSB] ^ divisor[MSB]).
  - neg_r = is_signed & dividend[MSB].
  - Operands: absolute values when is_signed, raw values otherwise.
  - Clear the partial remainder (WIDTH+1 bits) and count.
  - busy=1 from the cycle after E0.
- Each CALC edge:
  - shift {rem, quo} left 1, feeding the quotient register MSB into the rem LSB;
  - trial = shifted rem - divisor in WIDTH+1 bits;
  - no borrow: rem=trial, quo LSB=1; borrow: rem unchanged, quo LSB=0;
  - count += 1.
- FIX edge:
  - quotient = neg_q ? -quo : quo.
  - remainder = neg_r ? -rem : rem.
  - done=1 for exactly one cycle; busy=0; div_by_zero updated.
- Latency:
  - Normal operation: done is high in the cycle following edge E(WIDTH+1), i.e. 33 edges after the start edge for WIDTH=32. busy is high for WIDTH+1 cycles.
  - Divide by zero: skips CALC. Result is quotient=all ones, remainder=captured dividend (unmodified), div_by_zero=1. done is high after E1; busy is high for 1 cycle.
- Signed overflow (0x80000000 / -1): produces quotient=0x80000000, remainder=0, div_by_zero=0. No exception or special case.
- Truncation toward zero:
  - remainder takes the sign of the dividend;
  - |remainder| < |divisor|.
- Handshake:
  - start while busy=1 is ignored; the captured operands are not disturbed.
  - start in the done cycle (busy=0) is accepted. That start is not lost, and done drops next cycle.
- Outputs quotient, remainder and div_by_zero hold their values until the next FIX edge or rst. They do not change during CALC.
- done is never asserted without a preceding accepted start.

Test Plan:
- rst then DIVU 100/7 -> done exactly 33 edges after start; quotient=14, remainder=2, div_by_zero=0; busy high 33 cycles.
- DIV -7/2 (0xFFFFFFF9/0x2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. DIV 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
- 0xFFFFFFFF/2:
  - DIVU -> quotient=0x7FFFFFFF, remainder=1;
  - DIV -> quotient=0, remainder=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. DIVU 0x80000000/0xFFFFFFFF -> quotient=0, remainder=0x80000000.
- DIVU 5/0 -> done after 1 cycle of busy; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. A following DIVU 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- Three checks on handshake and reset:
  - Pulse start with 50/5 at cycle 10 of a 100/7 operation -> ignored; result 14/2.
  - Back-to-back start in the done cycle -> second result correct.
  - rst at cycle 15 -> outputs 0 and no done pulse.
